// File: rtl/piso_sel_sequencer_pkg.sv
// Shared types and defaults for the parallel-in/serial-out select sequencer.
// Optional parity bit is enabled by defining PISO_PARITY_EN (see piso_sel_sequencer.sv).
package piso_sel_sequencer_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_BIT_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    function automatic int sel_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_sel_sequencer_if.sv
// Parallel word handshake plus framed serial/select outputs of the sequencer.
// The slave modport is the sequencer side, the master modport is source/consumer.
interface piso_sel_sequencer_if
    import piso_sel_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = sel_w(WIDTH)
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, sel, ser_out, ser_valid, frame_start, frame_done, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, sel, ser_out, ser_valid, frame_start, frame_done, busy
    );
endinterface

// File: rtl/piso_sel_sequencer_bit_timer.sv
// Per-bit down-counter: load reloads BIT_CYCLES-1, tc_o flags the last cycle of a bit.
module piso_sel_sequencer_bit_timer
    import piso_sel_sequencer_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = TW'(BIT_CYCLES - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/piso_sel_sequencer.sv
// Holds an accepted parallel word and walks the mux select LSB first, one bit per BIT_CYCLES.
// Define PISO_PARITY_EN to append an even-parity bit after bit WIDTH-1.
//
//   state     | meaning
//   ST_IDLE   | waiting for a word, in_ready high
//   ST_SHIFT  | sending hold[sel], sel stepping 0..WIDTH-1
//   ST_PARITY | sending ^hold with sel parked at WIDTH-1
module piso_sel_sequencer
    import piso_sel_sequencer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int SEL_W      = sel_w(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    piso_sel_sequencer_if.slave bus
);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] hold_q, hold_d;

    logic tmr_load, tmr_en, tmr_tc;
    logic end_frame;
    logic in_ready_c, busy_c, ser_valid_c, ser_out_c, frame_start_c, frame_done_c;

    piso_sel_sequencer_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .tc_o   (tmr_tc)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        hold_d        = hold_q;
        tmr_load      = 1'b0;
        tmr_en        = 1'b0;
        end_frame     = 1'b0;
        in_ready_c    = 1'b0;
        busy_c        = 1'b0;
        ser_valid_c   = 1'b0;
        ser_out_c     = 1'b0;
        frame_start_c = 1'b0;
        frame_done_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    hold_d   = bus.in_data;
                    sel_d    = '0;
                    tmr_load = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy_c        = 1'b1;
                ser_valid_c   = 1'b1;
                ser_out_c     = hold_q[sel_q];
                frame_start_c = (sel_q == '0);
                tmr_en        = 1'b1;
                if (tmr_tc) begin
                    if (sel_q != SEL_LAST) begin
                        sel_d    = sel_q + 1'b1;
                        tmr_load = 1'b1;
                    end else begin
`ifdef PISO_PARITY_EN
                        tmr_load = 1'b1;
                        state_d  = ST_PARITY;
`else
                        end_frame = 1'b1;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                busy_c      = 1'b1;
                ser_valid_c = 1'b1;
                ser_out_c   = ^hold_q;
                tmr_en      = 1'b1;
                end_frame   = tmr_tc;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase

        // Final cycle of a frame doubles as an accept slot for gapless back-to-back frames.
        if (end_frame) begin
            frame_done_c = 1'b1;
            in_ready_c   = 1'b1;
            sel_d        = '0;
            if (bus.in_valid) begin
                hold_d   = bus.in_data;
                tmr_load = 1'b1;
                state_d  = ST_SHIFT;
            end else begin
                state_d  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
        end
    end

    // in_ready must read low for the whole reset window even though IDLE is the reset state.
    assign bus.in_ready    = in_ready_c & ~rst;
    assign bus.sel         = sel_q;
    assign bus.ser_out     = ser_out_c;
    assign bus.ser_valid   = ser_valid_c;
    assign bus.frame_start = frame_start_c;
    assign bus.frame_done  = frame_done_c;
    assign bus.busy        = busy_c;

endmodule

// File: tb/tb_piso_sel_sequencer.sv
// Directed bench for piso_sel_sequencer: BIT_CYCLES=1 and BIT_CYCLES=3 instances on one clock.
module tb_piso_sel_sequencer;

`ifdef PISO_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   fd_cnt  = 0;

    always #5 clk = ~clk;

    piso_sel_sequencer_if #(.WIDTH(8), .SEL_W(3)) bus1 ();
    piso_sel_sequencer_if #(.WIDTH(8), .SEL_W(3)) bus3 ();

    piso_sel_sequencer #(.WIDTH(8), .BIT_CYCLES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    piso_sel_sequencer #(.WIDTH(8), .BIT_CYCLES(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    always @(posedge clk) begin
        if (bus1.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_tests++;
        if (obs !== expd) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expd);
        end
    endtask

    function automatic logic [31:0] outs1();
        return {22'd0, bus1.in_ready, bus1.busy, bus1.ser_valid, bus1.ser_out,
                bus1.frame_start, bus1.frame_done, 1'b0, bus1.sel};
    endfunction

    // Checks one sampled cycle of bus1; j is the bit index within the frame.
    task automatic check_bit1(input string tag, input logic [7:0] d, input int j);
        logic [2:0] es;
        logic       eb;
        es = (j < 8) ? 3'(j) : 3'd7;
        eb = (j < 8) ? d[j] : ^d;
        check_eq($sformatf("%s sel%0d", tag, j), 32'(bus1.sel), 32'(es));
        check_eq($sformatf("%s ser%0d", tag, j), 32'(bus1.ser_out), 32'(eb));
        check_eq($sformatf("%s ctl%0d", tag, j),
                 {28'd0, bus1.ser_valid, bus1.busy, bus1.frame_start, bus1.frame_done},
                 {28'd0, 1'b1, 1'b1, (j == 0), (j == NB - 1)});
        check_eq($sformatf("%s rdy%0d", tag, j), 32'(bus1.in_ready), 32'(j == NB - 1));
    endtask

    // Entered at #1 after a posedge with bus1 idle; returns at #1 after a posedge, idle again.
    task automatic frame1(input string tag, input logic [7:0] d);
        bus1.in_data  = d;
        bus1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        bus1.in_data  = ~d;
        for (int j = 0; j < NB; j++) begin
            @(negedge clk);
            check_bit1(tag, d, j);
        end
        @(negedge clk);
        check_eq({tag, " idle"}, outs1(), 32'h0000_0200);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin
        logic [7:0] d;
        int         fd_before;
        int         b;

        bus1.in_data  = 8'h00;
        bus1.in_valid = 1'b0;
        bus3.in_data  = 8'h00;
        bus3.in_valid = 1'b0;

        // 1: reset state, release, and a mid-idle pulse
        #1;
        check_eq("rst outs", outs1(), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_eq("post-rst idle", outs1(), 32'h0000_0200);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("idle rst outs", outs1(), 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_eq("idle rst rdy", 32'(bus1.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 2: single frame, plus parity-zero word
        frame1("dc", 8'hDC);
        frame1("00", 8'h00);

        // 3: back-to-back frames with in_valid held high
        bus1.in_data  = 8'hDC;
        bus1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_data = 8'h5A;
        for (int i = 0; i < 2 * NB; i++) begin
            @(negedge clk);
            d = (i < NB) ? 8'hDC : 8'h5A;
            check_bit1("b2b", d, i % NB);
            if (i == NB - 1) begin
                @(posedge clk);
                #1;
                bus1.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("b2b idle", outs1(), 32'h0000_0200);
        @(posedge clk);
        #1;

        // 4: BIT_CYCLES=3 frame
        d = 8'h81;
        bus3.in_data  = d;
        bus3.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus3.in_valid = 1'b0;
        for (int i = 0; i < 3 * NB; i++) begin
            @(negedge clk);
            b = i / 3;
            check_eq($sformatf("bc3 sel%0d", i), 32'(bus3.sel), (b < 8) ? 32'(b) : 32'd7);
            check_eq($sformatf("bc3 ser%0d", i), 32'(bus3.ser_out), (b < 8) ? 32'(d[b]) : 32'(^d));
            check_eq($sformatf("bc3 ctl%0d", i),
                     {29'd0, bus3.ser_valid, bus3.frame_start, bus3.frame_done},
                     {29'd0, 1'b1, (b == 0), (i == 3 * NB - 1)});
        end
        @(negedge clk);
        check_eq("bc3 idle", {30'd0, bus3.busy, bus3.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 5: reset mid-frame at sel=4
        fd_before = fd_cnt;
        bus1.in_data  = 8'hDC;
        bus1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        for (int j = 0; j < 5; j++) @(negedge clk);
        check_eq("mid sel", 32'(bus1.sel), 32'd4);
        #2 rst = 1'b1;
        #1;
        check_eq("mid rst outs", outs1(), 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check_eq($sformatf("mid after%0d", j), outs1(), 32'h0000_0200);
        end
        check_eq("mid no done", 32'(fd_cnt - fd_before), 32'd0);
        @(posedge clk);
        #1;
        frame1("5a", 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
